// File: rtl/caf_pkg.sv
// Shared constants and FSM encoding for the CAF peak selector.
// Optional feature macro used by this block: CAF_PEAK_SECOND_EN.
package caf_pkg;

  localparam int OUT_MAX_BITS_DEF        = 64;
  localparam int LENGTH_COUNTER_BITS_DEF = 3;
  localparam int FOAS_DEF                = 3;
  localparam int FOAS_COUNTER_BITS_DEF   = 3;

  typedef enum logic {
    ACCUM  = 1'b0,
    OUTPUT = 1'b1
  } caf_state_e;

endpackage

// File: rtl/caf_peak_cmp.sv
// Running-max compare/replace datapath: strict greater-than replaces, ties keep the earliest beat.
// With CAF_PEAK_SECOND_EN defined it also tracks the second-largest magnitude.
module caf_peak_cmp
  import caf_pkg::*;
#(
  parameter int out_max_bits        = OUT_MAX_BITS_DEF,
  parameter int length_counter_bits = LENGTH_COUNTER_BITS_DEF,
  parameter int foas_counter_bits   = FOAS_COUNTER_BITS_DEF
) (
  input  logic                           first,
  input  logic [out_max_bits-1:0]        beat_max,
  input  logic [length_counter_bits-1:0] beat_index,
  input  logic [foas_counter_bits-1:0]   beat_freq,
  input  logic [out_max_bits-1:0]        cur_max,
  input  logic [length_counter_bits-1:0] cur_index,
  input  logic [foas_counter_bits-1:0]   cur_freq,
`ifdef CAF_PEAK_SECOND_EN
  input  logic [out_max_bits-1:0]        cur_second,
  output logic [out_max_bits-1:0]        next_second,
`endif
  output logic [out_max_bits-1:0]        next_max,
  output logic [length_counter_bits-1:0] next_index,
  output logic [foas_counter_bits-1:0]   next_freq
);

  logic take;

  // NOTE: every always_comb output gets a value on every path (here by
  // unconditional assignment) so no latch can be inferred.
  always_comb begin
    take       = first || (beat_max > cur_max);
    next_max   = take ? beat_max   : cur_max;
    next_index = take ? beat_index : cur_index;
    next_freq  = take ? beat_freq  : cur_freq;
  end

`ifdef CAF_PEAK_SECOND_EN
  // A new maximum demotes the old one; otherwise the beat may still beat the runner-up.
  always_comb begin
    next_second = cur_second;
    if (first)
      next_second = '0;
    else if (beat_max > cur_max)
      next_second = cur_max;
    else if (beat_max > cur_second)
      next_second = beat_max;
  end
`endif

endmodule

// File: rtl/caf_peak_select.sv
// Frame-level peak selector: accumulates foas slice beats, then presents the frame peak.
// Defining CAF_PEAK_SECOND_EN adds the second_max output.
module caf_peak_select
  import caf_pkg::*;
#(
  parameter int out_max_bits        = OUT_MAX_BITS_DEF,
  parameter int length_counter_bits = LENGTH_COUNTER_BITS_DEF,
  parameter int foas                = FOAS_DEF,
  parameter int foas_counter_bits   = FOAS_COUNTER_BITS_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_tvalid,
  output logic                           in_tready,
  input  logic [out_max_bits-1:0]        in_out_max,
  input  logic [length_counter_bits-1:0] in_index,
  input  logic [foas_counter_bits-1:0]   in_freq_index,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic [out_max_bits-1:0]        peak_max,
  output logic [length_counter_bits-1:0] peak_index,
  output logic [foas_counter_bits-1:0]   peak_freq_index,
`ifdef CAF_PEAK_SECOND_EN
  output logic [out_max_bits-1:0]        second_max,
`endif
  output logic                           seq_error
);

  localparam logic [foas_counter_bits-1:0] LAST_BEAT = foas_counter_bits'(foas - 1);

  caf_state_e                     state, state_next;
  logic [foas_counter_bits-1:0]   beat_cnt;
  logic                           beat_fire, result_fire, last_beat;
  logic [out_max_bits-1:0]        next_max;
  logic [length_counter_bits-1:0] next_index;
  logic [foas_counter_bits-1:0]   next_freq;
`ifdef CAF_PEAK_SECOND_EN
  logic [out_max_bits-1:0]        next_second;
`endif

  assign last_beat   = (beat_cnt == LAST_BEAT);
  assign beat_fire   = in_tvalid && in_tready;
  assign result_fire = m_tvalid && m_tready;

  // NOTE: reset here is synchronous, so rst is just the highest-priority
  // branch inside the clocked block, never in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_tready  = 1'b0;
    m_tvalid   = 1'b0;
    case (state)
      ACCUM: begin
        in_tready = 1'b1;
        if (in_tvalid && last_beat) state_next = OUTPUT;
      end
      OUTPUT: begin
        m_tvalid = 1'b1;
        if (m_tready) state_next = ACCUM;
      end
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)              beat_cnt <= '0;
    else if (result_fire) beat_cnt <= '0;
    else if (beat_fire)   beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
  end

  caf_peak_cmp #(
    .out_max_bits        (out_max_bits),
    .length_counter_bits (length_counter_bits),
    .foas_counter_bits   (foas_counter_bits)
  ) u_cmp (
    .first      (beat_cnt == '0),
    .beat_max   (in_out_max),
    .beat_index (in_index),
    .beat_freq  (in_freq_index),
    .cur_max    (peak_max),
    .cur_index  (peak_index),
    .cur_freq   (peak_freq_index),
`ifdef CAF_PEAK_SECOND_EN
    .cur_second (second_max),
    .next_second(next_second),
`endif
    .next_max   (next_max),
    .next_index (next_index),
    .next_freq  (next_freq)
  );

  // Running registers double as the result: after the last beat they hold the frame peak.
  always_ff @(posedge clk) begin
    if (rst) begin
      peak_max        <= '0;
      peak_index      <= '0;
      peak_freq_index <= '0;
    end else if (beat_fire) begin
      peak_max        <= next_max;
      peak_index      <= next_index;
      peak_freq_index <= next_freq;
    end
  end

`ifdef CAF_PEAK_SECOND_EN
  always_ff @(posedge clk) begin
    if (rst)            second_max <= '0;
    else if (beat_fire) second_max <= next_second;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst)                                          seq_error <= 1'b0;
    else if (beat_fire && (in_freq_index != beat_cnt)) seq_error <= 1'b1;
  end

endmodule
